// File: rtl/onchip_mem_arbiter.sv
// onchip_mem_arbiter: multi-channel arbiter onto a single on-chip RAM port with lock and ordered read returns
module onchip_mem_arbiter #(
  parameter int NUM_CH   = 4,
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int READ_LAT = 1,
  parameter int ARB_MODE = 0,
  parameter int MAX_LOCK = 16,
  localparam int BE_W    = DATA_W / 8,
  localparam int CW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk_clk,
  input  logic                     reset_reset,
  input  logic [NUM_CH-1:0]        req_valid,
  output logic [NUM_CH-1:0]        req_ready,
  input  logic [NUM_CH-1:0]        req_write,
  input  logic [NUM_CH-1:0]        req_lock,
  input  logic [NUM_CH*ADDR_W-1:0] req_addr,
  input  logic [NUM_CH*DATA_W-1:0] req_wdata,
  input  logic [NUM_CH*BE_W-1:0]   req_be,
  output logic [NUM_CH-1:0]        rsp_valid,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic [ADDR_W-1:0]        mem_address,
  output logic                     mem_chipselect,
  output logic                     mem_clken,
  output logic                     mem_write,
  input  logic [DATA_W-1:0]        mem_readdata,
  output logic [DATA_W-1:0]        mem_writedata,
  output logic [BE_W-1:0]          mem_byteenable
);
  logic [CW-1:0] last_grant, lock_ch, gnt_ch, iss_ch;
  logic [CW-1:0] cand [NUM_CH];
  logic [CW-1:0] pc [READ_LAT];
  logic [READ_LAT-1:0] pv;
  logic [7:0] lock_cnt;
  logic lock_on, hold, any;

  // cand[i] is the i-th channel in search order; fixed priority always starts at 0
  for (genvar g = 0; g < NUM_CH; g++) begin : g_cand
    assign cand[g] = CW'((g + ((ARB_MODE != 0) ? 0 : int'(last_grant) + 1)) % NUM_CH);
  end

  assign hold = lock_on & req_valid[lock_ch] & (lock_cnt != 8'(MAX_LOCK));

  always_comb begin
    gnt_ch = '0;
    any = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (req_valid[cand[i]]) begin
        gnt_ch = cand[i];
        any = 1'b1;
      end
    if (hold) begin
      gnt_ch = lock_ch;
      any = 1'b1;
    end
  end

  assign req_ready = (any && !reset_reset) ? (NUM_CH'(1) << gnt_ch) : '0;

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      last_grant     <= CW'(NUM_CH - 1);
      lock_ch        <= '0;
      lock_on        <= 1'b0;
      lock_cnt       <= '0;
      iss_ch         <= '0;
      pv             <= '0;
      for (int i = 0; i < READ_LAT; i++) pc[i] <= '0;
      mem_chipselect <= 1'b0;
      mem_write      <= 1'b0;
      mem_clken      <= 1'b0;
      mem_address    <= '0;
      mem_writedata  <= '0;
      mem_byteenable <= '0;
      rsp_valid      <= '0;
      rsp_rdata      <= '0;
    end else begin
      mem_clken      <= 1'b1;
      mem_chipselect <= any;
      mem_write      <= any & req_write[gnt_ch];
      if (any) begin
        mem_address    <= req_addr[gnt_ch*ADDR_W +: ADDR_W];
        mem_writedata  <= req_wdata[gnt_ch*DATA_W +: DATA_W];
        mem_byteenable <= req_be[gnt_ch*BE_W +: BE_W];
        last_grant     <= gnt_ch;
        iss_ch         <= gnt_ch;
      end
      // a fresh lock (new channel or after the beat limit) restarts the count at one
      if (any && req_lock[gnt_ch]) begin
        lock_on  <= 1'b1;
        lock_ch  <= gnt_ch;
        lock_cnt <= hold ? lock_cnt + 8'd1 : 8'd1;
      end else begin
        lock_on  <= 1'b0;
        lock_cnt <= '0;
      end
      pv[0] <= mem_chipselect & ~mem_write;
      pc[0] <= iss_ch;
      for (int i = 1; i < READ_LAT; i++) begin
        pv[i] <= pv[i-1];
        pc[i] <= pc[i-1];
      end
      rsp_valid <= pv[READ_LAT-1] ? (NUM_CH'(1) << pc[READ_LAT-1]) : '0;
      if (pv[READ_LAT-1]) rsp_rdata <= mem_readdata;
    end
  end
endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// tb_onchip_mem_arbiter: directed checks of arbitration, lock limit, RAM access timing and reset
module tb_onchip_mem_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1;
  logic [3:0] req_valid = '0, req_write = '0, req_lock = '0;
  logic [39:0] req_addr = '0;
  logic [127:0] req_wdata = '0;
  logic [15:0] req_be = '0;
  logic [3:0] req_ready, rsp_valid, fp_ready, fp_rsp_valid;
  logic [31:0] rsp_rdata, mem_readdata, mem_writedata, fp_rsp_rdata, fp_writedata;
  logic [9:0] mem_address, fp_address;
  logic mem_chipselect, mem_clken, mem_write, fp_cs, fp_clken, fp_write;
  logic [3:0] mem_byteenable, fp_be;
  logic [31:0] ram [1024];
  int tests = 0, fails = 0;

  onchip_mem_arbiter #(.MAX_LOCK(4)) dut (
    .clk_clk(clk), .reset_reset(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_lock(req_lock), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_be(req_be), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .mem_address(mem_address),
    .mem_chipselect(mem_chipselect), .mem_clken(mem_clken), .mem_write(mem_write),
    .mem_readdata(mem_readdata), .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable)
  );

  onchip_mem_arbiter #(.ARB_MODE(1)) dut_fp (
    .clk_clk(clk), .reset_reset(rst), .req_valid(req_valid), .req_ready(fp_ready),
    .req_write(req_write), .req_lock(req_lock), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_be(req_be), .rsp_valid(fp_rsp_valid), .rsp_rdata(fp_rsp_rdata), .mem_address(fp_address),
    .mem_chipselect(fp_cs), .mem_clken(fp_clken), .mem_write(fp_write),
    .mem_readdata(32'h0), .mem_writedata(fp_writedata), .mem_byteenable(fp_be)
  );

  always @(posedge clk)
    if (mem_chipselect && mem_clken) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
      end else mem_readdata <= ram[mem_address];
    end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int c, input logic w, input logic lk, input logic [9:0] a,
                        input logic [31:0] d, input logic [3:0] be);
    req_valid[c] = 1'b1;
    req_write[c] = w;
    req_lock[c] = lk;
    req_addr[c*10 +: 10] = a;
    req_wdata[c*32 +: 32] = d;
    req_be[c*4 +: 4] = be;
  endtask

  task automatic do_reset;
    req_valid = '0;
    req_lock = '0;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    req_valid = 4'hf;
    #2;
    tests++; if (req_ready !== 4'b0) begin fails++; $display("FAIL rst_ready got %b want 0000", req_ready); end
    tests++; if (fp_ready !== 4'b0) begin fails++; $display("FAIL rst_fp_ready got %b want 0000", fp_ready); end
    tests++; if ({mem_chipselect, mem_write, mem_clken} !== 3'b0) begin fails++; $display("FAIL rst_mem_ctl got %b want 000", {mem_chipselect, mem_write, mem_clken}); end
    tests++; if ({mem_address, mem_writedata, mem_byteenable} !== 46'b0) begin fails++; $display("FAIL rst_mem_data got %h want 0", {mem_address, mem_writedata, mem_byteenable}); end
    tests++; if ({rsp_valid, rsp_rdata} !== 36'b0) begin fails++; $display("FAIL rst_rsp got %h want 0", {rsp_valid, rsp_rdata}); end
    req_valid = '0;
    tick;
    rst = 1'b0;
    tick;
    tests++; if (mem_clken !== 1'b1) begin fails++; $display("FAIL clken got %b want 1", mem_clken); end
  endtask

  task automatic test_single_read;
    set_ch(2, 1, 0, 10'h05, 32'hDEADBEEF, 4'hf);
    #1;
    tests++; if (req_ready !== 4'b0100) begin fails++; $display("FAIL wr_ready got %b want 0100", req_ready); end
    tick;
    req_valid = '0;
    tests++; if ({mem_chipselect, mem_write, mem_address, mem_writedata} !== {2'b11, 10'h05, 32'hDEADBEEF}) begin fails++; $display("FAIL wr_issue got %h want %h", {mem_chipselect, mem_write, mem_address, mem_writedata}, {2'b11, 10'h05, 32'hDEADBEEF}); end
    tick;
    tests++; if ({mem_chipselect, mem_write, mem_address} !== {2'b00, 10'h05}) begin fails++; $display("FAIL idle_hold got %h want %h", {mem_chipselect, mem_write, mem_address}, {2'b00, 10'h05}); end
    set_ch(2, 0, 0, 10'h05, 32'h0, 4'h0);
    #1;
    tests++; if (req_ready !== 4'b0100) begin fails++; $display("FAIL rd_ready got %b want 0100", req_ready); end
    tick;
    req_valid = '0;
    tests++; if ({mem_chipselect, mem_write, mem_address} !== {2'b10, 10'h05}) begin fails++; $display("FAIL rd_issue got %h want %h", {mem_chipselect, mem_write, mem_address}, {2'b10, 10'h05}); end
    tick;
    tests++; if (rsp_valid !== 4'b0) begin fails++; $display("FAIL rd_early got %b want 0000", rsp_valid); end
    tick;
    tests++; if ({rsp_valid, rsp_rdata} !== {4'b0100, 32'hDEADBEEF}) begin fails++; $display("FAIL rd_rsp got %h want %h", {rsp_valid, rsp_rdata}, {4'b0100, 32'hDEADBEEF}); end
    tick;
    tests++; if ({rsp_valid, rsp_rdata} !== {4'b0000, 32'hDEADBEEF}) begin fails++; $display("FAIL rd_hold got %h want %h", {rsp_valid, rsp_rdata}, {4'b0000, 32'hDEADBEEF}); end
  endtask

  task automatic test_round_robin;
    logic [3:0] exp;
    do_reset;
    for (int k = 0; k < 10; k++) begin
      if (k < 6) for (int c = 0; c < 4; c++) set_ch(c, 0, 0, 10'(c), 32'h0, 4'h0);
      else req_valid = '0;
      #1;
      exp = 4'b0001 << (k % 4);
      if (k < 6) begin
        tests++; if (req_ready !== exp) begin fails++; $display("FAIL rr_grant[%0d] got %b want %b", k, req_ready, exp); end
      end
      exp = (k >= 3 && k < 9) ? 4'b0001 << ((k - 3) % 4) : 4'b0;
      tests++; if (rsp_valid !== exp) begin fails++; $display("FAIL rr_rsp[%0d] got %b want %b", k, rsp_valid, exp); end
      tick;
    end
  endtask

  task automatic test_lock_limit;
    logic [3:0] vm [8] = '{4'h6, 4'h6, 4'h6, 4'h6, 4'h6, 4'h6, 4'h4, 4'h6};
    logic [3:0] ex [8] = '{4'h2, 4'h2, 4'h2, 4'h2, 4'h4, 4'h2, 4'h4, 4'h2};
    do_reset;
    for (int k = 0; k < 8; k++) begin
      set_ch(1, 1, 1, 10'h20, 32'h0, 4'h0);
      set_ch(2, 1, 0, 10'h21, 32'h0, 4'h0);
      req_valid = vm[k];
      #1;
      tests++; if (req_ready !== ex[k]) begin fails++; $display("FAIL lock_grant[%0d] got %b want %b", k, req_ready, ex[k]); end
      tick;
    end
    req_valid = '0;
    req_lock = '0;
    tick;
  endtask

  task automatic test_fixed_priority;
    logic [3:0] exp;
    do_reset;
    for (int k = 0; k < 6; k++) begin
      set_ch(0, 1, 0, 10'h30, 32'h0, 4'h0);
      set_ch(3, 1, 0, 10'h31, 32'h0, 4'h0);
      if (k >= 4) req_valid[0] = 1'b0;
      #1;
      exp = (k < 4) ? 4'b0001 : 4'b1000;
      tests++; if (fp_ready !== exp) begin fails++; $display("FAIL fp_grant[%0d] got %b want %b", k, fp_ready, exp); end
      tick;
    end
    req_valid = '0;
    tick;
  endtask

  task automatic test_byte_write;
    set_ch(0, 1, 0, 10'h10, 32'hFFFFFFFF, 4'hf);
    #1;
    tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL bw_ready got %b want 0001", req_ready); end
    tick;
    set_ch(0, 1, 0, 10'h10, 32'h11223344, 4'b0011);
    tick;
    tests++; if ({mem_byteenable, mem_writedata} !== {4'b0011, 32'h11223344}) begin fails++; $display("FAIL bw_issue got %h want %h", {mem_byteenable, mem_writedata}, {4'b0011, 32'h11223344}); end
    set_ch(0, 0, 0, 10'h10, 32'h0, 4'h0);
    tick;
    req_valid = '0;
    tick;
    tick;
    tests++; if ({rsp_valid, rsp_rdata} !== {4'b0001, 32'hFFFF3344}) begin fails++; $display("FAIL bw_rsp got %h want %h", {rsp_valid, rsp_rdata}, {4'b0001, 32'hFFFF3344}); end
  endtask

  task automatic test_reset_mid;
    tick;
    set_ch(1, 0, 0, 10'h05, 32'h0, 4'h0);
    #1;
    tests++; if (req_ready !== 4'b0010) begin fails++; $display("FAIL rm_ready got %b want 0010", req_ready); end
    tick;
    tests++; if (mem_chipselect !== 1'b1) begin fails++; $display("FAIL rm_issue got %b want 1", mem_chipselect); end
    rst = 1'b1;
    #1;
    tests++; if ({mem_chipselect, mem_write, mem_clken, mem_address, mem_writedata, mem_byteenable} !== 49'b0) begin fails++; $display("FAIL rm_mem got %h want 0", {mem_chipselect, mem_write, mem_clken, mem_address, mem_writedata, mem_byteenable}); end
    tests++; if ({req_ready, rsp_valid, rsp_rdata} !== 40'b0) begin fails++; $display("FAIL rm_rsp got %h want 0", {req_ready, rsp_valid, rsp_rdata}); end
    req_valid = '0;
    tick;
    tick;
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tests++; if (rsp_valid !== 4'b0) begin fails++; $display("FAIL rm_ghost[%0d] got %b want 0000", k, rsp_valid); end
      tick;
    end
    set_ch(1, 0, 0, 10'h05, 32'h0, 4'h0);
    tick;
    req_valid = '0;
    tick;
    tick;
    tests++; if ({rsp_valid, rsp_rdata} !== {4'b0010, 32'hDEADBEEF}) begin fails++; $display("FAIL rm_after got %h want %h", {rsp_valid, rsp_rdata}, {4'b0010, 32'hDEADBEEF}); end
  endtask

  initial begin
    test_reset;
    test_single_read;
    test_round_robin;
    test_lock_limit;
    test_fixed_priority;
    test_byte_write;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
